// File: rtl/rho_pi_pkg.sv
// Shared constants for the rho/pi lane stages: lane count, rotation offsets,
// pi source-lane map and the sequencer state encoding.
package rho_pi_pkg;

  localparam int LANES = 25;
  localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // r[x][y] flattened by A-lane k = 5*y + x
  function automatic logic [5:0] rot_amt(input logic [4:0] k);
    logic [5:0] r;
    case (k)
      5'd0:  r = 6'd0;   5'd1:  r = 6'd1;   5'd2:  r = 6'd62;
      5'd3:  r = 6'd28;  5'd4:  r = 6'd27;  5'd5:  r = 6'd36;
      5'd6:  r = 6'd44;  5'd7:  r = 6'd6;   5'd8:  r = 6'd55;
      5'd9:  r = 6'd20;  5'd10: r = 6'd3;   5'd11: r = 6'd10;
      5'd12: r = 6'd43;  5'd13: r = 6'd25;  5'd14: r = 6'd39;
      5'd15: r = 6'd41;  5'd16: r = 6'd45;  5'd17: r = 6'd15;
      5'd18: r = 6'd21;  5'd19: r = 6'd8;   5'd20: r = 6'd18;
      5'd21: r = 6'd2;   5'd22: r = 6'd61;  5'd23: r = 6'd56;
      5'd24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // B lane holding A lane k: lane(y, (2x+3y) mod 5), precomputed
  function automatic logic [4:0] src_lane(input logic [4:0] k);
    logic [4:0] s;
    case (k)
      5'd0:  s = 5'd0;   5'd1:  s = 5'd10;  5'd2:  s = 5'd20;
      5'd3:  s = 5'd5;   5'd4:  s = 5'd15;  5'd5:  s = 5'd16;
      5'd6:  s = 5'd1;   5'd7:  s = 5'd11;  5'd8:  s = 5'd21;
      5'd9:  s = 5'd6;   5'd10: s = 5'd7;   5'd11: s = 5'd17;
      5'd12: s = 5'd2;   5'd13: s = 5'd12;  5'd14: s = 5'd22;
      5'd15: s = 5'd23;  5'd16: s = 5'd8;   5'd17: s = 5'd18;
      5'd18: s = 5'd3;   5'd19: s = 5'd13;  5'd20: s = 5'd14;
      5'd21: s = 5'd24;  5'd22: s = 5'd9;   5'd23: s = 5'd19;
      5'd24: s = 5'd4;
      default: s = 5'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rho_pi_decoder_lane_rotr.sv
// Combinational rotate-right of one lane; amount is reduced mod W.
module lane_rotr #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic [5:0]   amt,
  output logic [W-1:0] dout
);

  logic [31:0]    sh;
  logic [2*W-1:0] dbl;

  always_comb begin
    sh   = 32'(amt) % W;
    dbl  = {din, din} >> sh;
    dout = dbl[W-1:0];
  end

endmodule

// File: rtl/rho_pi_decoder.sv
// Inverse rho/pi stage: reads 25 encoded lanes of one data set, un-permutes
// and un-rotates them, and writes the recovered lanes in ascending order.
module rho_pi_decoder
  import rho_pi_pkg::*;
#(
  parameter int W    = 64,
  parameter int IDXW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDXW-1:0]   file_index,
  output logic              finish,
  output logic              rd_en,
  output logic [IDXW+4:0]   rd_addr,
  input  logic [W-1:0]      rd_data,
  output logic              wr_en,
  output logic [IDXW+4:0]   wr_addr,
  output logic [W-1:0]      wr_data
);

  localparam int STAGES = 2;

  state_t                      state, state_nxt;
  logic [IDXW-1:0]             idx_q;
  logic [4:0]                  cnt;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES-1:0][4:0]      lane_pipe;
  logic [5:0]                  amt;
  logic [W-1:0]                rot_out;
  logic                        issue, accept, finish_d;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // DRAIN ends once the final read's data is in the rotate stage
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN:          if (cnt == LAST_LANE) state_nxt = S_DRAIN;
      S_DRAIN:        if (vld_pipe[1] && !vld_pipe[0]) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue    = (state == S_RUN);
    accept   = ((state == S_IDLE) || (state == S_DONE)) && start;
    finish_d = (state == S_DONE);
  end

  assign rd_en = vld_pipe[0];
  assign wr_en = vld_pipe[STAGES];
  assign amt   = rot_amt(lane_pipe[1]);

  lane_rotr #(.W(W)) u_rotr (
    .din  (rd_data),
    .amt  (amt),
    .dout (rot_out)
  );

  // finish trails DONE by one edge so it drops one cycle into a new run
  always_ff @(posedge clk) begin
    if (rst) begin
      finish    <= 1'b0;
      vld_pipe  <= '0;
      lane_pipe <= '0;
      cnt       <= '0;
      idx_q     <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      finish   <= finish_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      if (accept) begin
        idx_q <= file_index;
        cnt   <= '0;
      end else if (issue && (cnt != LAST_LANE)) begin
        cnt <= cnt + 5'd1;
      end
      if (issue) begin
        rd_addr      <= {idx_q, src_lane(cnt)};
        lane_pipe[0] <= cnt;
      end
      lane_pipe[1] <= lane_pipe[0];
      if (vld_pipe[1]) begin
        wr_data <= rot_out;
        wr_addr <= {idx_q, lane_pipe[1]};
      end
    end
  end

endmodule

// File: tb/tb_rho_pi_decoder.sv
// Bench for rho_pi_decoder: memory model, reference encoder, write scoreboard.
module tb_rho_pi_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  file_index = '0;
  logic        finish, rd_en, wr_en;
  logic [14:0] rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;

  rho_pi_decoder #(.W(64), .IDXW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .file_index(file_index),
    .finish(finish), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [63:0] imem [0:32767];
  always @(posedge clk) if (rd_en === 1'b1) rd_data <= imem[rd_addr];

  typedef struct { logic [14:0] addr; logic [63:0] data; int cyc; } exp_t;
  typedef struct {
    logic [9:0] idx; logic [4:0] src; logic [63:0] din;
    logic [4:0] dst; logic [63:0] dout; int hold;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, wr_cnt = 0, runs = 0;
  int   cur_t0 = -100;
  logic [9:0] cur_idx = '0;
  int   rtab [5][5] = '{'{0,36,3,41,18}, '{1,44,10,45,2}, '{62,6,43,15,61},
                        '{28,55,25,21,56}, '{27,20,39,8,14}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // one cycle: sample at the falling edge, scoreboard any write
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      chk("wr_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", wr_data, e.data);
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (cyc == cur_t0 + 1) begin
      chk("rd_first_en", 64'(rd_en), 64'd1);
      chk("rd_first_addr", 64'(rd_addr), 64'({cur_idx, 5'd0}));
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
  endfunction

  task automatic encode(input logic [9:0] idx, input logic [63:0] a [25]);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        imem[{idx, 5'(5 * ((2 * x + 3 * y) % 5) + y)}] = rotl(a[5 * y + x], rtab[x][y]);
  endtask

  task automatic push_run(input logic [9:0] idx, input logic [63:0] a [25], input int t0);
    for (int k = 0; k < 25; k++) exp_q.push_back('{{idx, 5'(k)}, a[k], t0 + 3 + k});
  endtask

  task automatic do_run(input logic [9:0] idx, input logic [63:0] a [25], input int hold);
    int lat = -1;
    file_index = idx;
    start = 1'b1;
    cur_t0 = cyc + 1;
    cur_idx = idx;
    push_run(idx, a, cur_t0);
    for (int i = 0; i < hold; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (cyc > cur_t0 + 1 && finish === 1'b1) lat = cyc - cur_t0;
      else tick();
    end
    chk("finish_latency", 64'(lat), 64'd28);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (lat >= 0) runs++;
    exp_q.delete();
  endtask

  task automatic rand_set(output logic [63:0] a [25]);
    for (int k = 0; k < 25; k++) a[k] = {$urandom, $urandom};
  endtask

  initial begin
    vec_t        vecs [5];
    logic [63:0] a [25];
    logic [63:0] b [25];
    int          wc, lat;

    vecs[0] = '{10'd0,    5'd10, 64'h1,                   5'd1,  64'h8000_0000_0000_0000, 3};
    vecs[1] = '{10'd0,    5'd0,  64'hDEAD_BEEF_0123_4567, 5'd0,  64'hDEAD_BEEF_0123_4567, 1};
    vecs[2] = '{10'd2,    5'd1,  64'h1,                   5'd6,  64'h0000_0000_0010_0000, 2};
    vecs[3] = '{10'd1023, 5'd24, 64'hF,                   5'd21, 64'hC000_0000_0000_0003, 1};
    vecs[4] = '{10'd511,  5'd4,  64'h1,                   5'd24, 64'h0004_0000_0000_0000, 1};

    // reset and idle
    for (int i = 0; i < 5; i++) tick();
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    rst = 1'b0;
    wc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || finish !== 1'b0) wc++;
    end
    chk("idle_quiet", 64'(wc), 64'd0);

    // single-lane vectors
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 25; k++) begin
        imem[{vecs[v].idx, 5'(k)}] = '0;
        a[k] = '0;
      end
      imem[{vecs[v].idx, vecs[v].src}] = vecs[v].din;
      a[vecs[v].dst] = vecs[v].dout;
      do_run(vecs[v].idx, a, vecs[v].hold);
    end

    // round trip over eight sets, restarting after each finish
    wc = wr_cnt;
    runs = 0;
    for (int s = 0; s < 8; s++) begin
      rand_set(a);
      encode(10'(s), a);
      do_run(10'(s), a, 1);
    end
    chk("rt_runs", 64'(runs), 64'd8);
    chk("rt_writes", 64'(wr_cnt - wc), 64'd200);

    // reset in the middle of a run
    rand_set(a);
    encode(10'd5, a);
    file_index = 10'd5;
    start = 1'b1;
    cur_t0 = cyc + 1;
    cur_idx = 10'd5;
    push_run(10'd5, a, cur_t0);
    tick();
    start = 1'b0;
    while (cyc < cur_t0 + 12) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
    chk("mid_rst_finish", 64'(finish), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd15);
    exp_q.delete();
    rst = 1'b0;
    wc = wr_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_rst_no_wr", 64'(wr_cnt - wc), 64'd0);
    rand_set(a);
    encode(10'd1023, a);
    do_run(10'd1023, a, 1);

    // start held 30 cycles, index changed at cycle 5
    rand_set(a);
    encode(10'd3, a);
    rand_set(b);
    encode(10'd9, b);
    file_index = 10'd3;
    start = 1'b1;
    cur_t0 = cyc + 1;
    cur_idx = 10'd3;
    push_run(10'd3, a, cur_t0);
    push_run(10'd9, b, cur_t0 + 28);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cyc == cur_t0 + 5) file_index = 10'd9;
      if (cyc == cur_t0 + 27) chk("hold_fin_pre", 64'(finish), 64'd0);
      if (cyc == cur_t0 + 28) chk("hold_fin_rise", 64'(finish), 64'd1);
      if (cyc == cur_t0 + 29) chk("hold_fin_fall", 64'(finish), 64'd0);
    end
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      if (finish === 1'b1) lat = cyc - (cur_t0 + 28);
      else tick();
    end
    chk("hold_2nd_latency", 64'(lat), 64'd28);
    chk("hold_writes_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
